// File: rtl/full_adder.sv
// Registered ripple-carry adder: WIDTH-bit sum, carry-out and signed overflow,
// with one cycle of latency and a result every cycle.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             Clock_In,
  input  logic             Reset_N_In,
  input  logic             Valid_In,
  input  logic [WIDTH-1:0] Data_A_In,
  input  logic [WIDTH-1:0] Data_B_In,
  input  logic             Carry_In,
  output logic             Valid_Out,
  output logic [WIDTH-1:0] Sum_Out,
  output logic             Carry_Out,
  output logic             Overflow_Out
);

  // Handshake: Valid_In qualifies the operands in the cycle it is high, and
  // Valid_Out pulses for exactly one cycle with the matching result on the
  // next edge. There is no ready, so every valid beat is accepted.

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_core;
  logic             ovf_core;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;
  logic             ovf_d, ovf_q;

  always_comb begin
    carry    = '0;
    sum_core = '0;
    carry[0] = Carry_In;
    for (int i = 0; i < WIDTH; i++) begin
      sum_core[i] = Data_A_In[i] ^ Data_B_In[i] ^ carry[i];
      carry[i+1]  = (Data_A_In[i] & Data_B_In[i]) |
                    (Data_A_In[i] & carry[i])     |
                    (Data_B_In[i] & carry[i]);
    end
    // For WIDTH=1 the carry into the MSB is Carry_In itself.
    ovf_core = carry[WIDTH] ^ carry[WIDTH-1];
  end

  // Idle cycles keep the last result; the mux stops idle-cycle data reaching the flops.
  always_comb begin
    valid_d = Valid_In;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (Valid_In) begin
      sum_d   = sum_core;
      carry_d = carry[WIDTH];
      ovf_d   = ovf_core;
    end
  end

  always_ff @(posedge Clock_In) begin
    if (!Reset_N_In) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Valid_Out    = valid_q;
  assign Sum_Out      = sum_q;
  assign Carry_Out    = carry_q;
  assign Overflow_Out = ovf_q;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: a 1-bit and an 8-bit instance driven from vector
// tables, hand-written hold/reset sequences and a randomized run.
module tb_full_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       v1, a1, b1, c1;
  logic       vo1, s1, co1, ov1;

  logic       v8, c8;
  logic [7:0] a8, b8;
  logic       vo8, co8, ov8;
  logic [7:0] s8;

  full_adder #(.WIDTH(1)) u_fa1 (
    .Clock_In(clk), .Reset_N_In(rst_n), .Valid_In(v1),
    .Data_A_In(a1), .Data_B_In(b1), .Carry_In(c1),
    .Valid_Out(vo1), .Sum_Out(s1), .Carry_Out(co1), .Overflow_Out(ov1)
  );

  full_adder #(.WIDTH(8)) u_fa8 (
    .Clock_In(clk), .Reset_N_In(rst_n), .Valid_In(v8),
    .Data_A_In(a8), .Data_B_In(b8), .Carry_In(c8),
    .Valid_Out(vo8), .Sum_Out(s8), .Carry_Out(co8), .Overflow_Out(ov8)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       a, b, cin;
    logic [1:0] exp_cs;
    logic       exp_ovf;
  } vec1_t;

  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_co, exp_ovf;
  } vec8_t;

  vec1_t tbl1[8];
  vec8_t tbl8[6];

  // scoreboard entries are {ovf, carry, sum}
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned sum at 9 bits, overflow from the true signed result range.
  function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int         ua, sa;
    logic [8:0] u9;
    logic       ovf;
    ua  = int'(a) + int'(b) + int'(cin);
    sa  = int'($signed(a)) + int'($signed(b)) + int'(cin);
    u9  = ua[8:0];
    ovf = (sa > 127) || (sa < -128);
    return {ovf, u9[8], u9[7:0]};
  endfunction

  logic [9:0] m_res;
  logic       m_valid;
  logic [9:0] got;

  initial begin
    tbl1[0] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl1[1] = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b1};
    tbl1[2] = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0};
    tbl1[3] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0};
    tbl1[4] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0};
    tbl1[5] = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0};
    tbl1[6] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b1};
    tbl1[7] = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b0};

    tbl8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl8[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl8[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl8[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    tbl8[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};

    // reset held two edges with valid operands present
    rst_n = 1'b0;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_valid1", vo1, 1'b0);
      check("rst_sum1", {co1, s1, ov1}, 3'b000);
      check("rst_valid8", vo8, 1'b0);
      check("rst_sum8", s8, 8'h00);
      check("rst_co_ovf8", {co8, ov8}, 2'b00);
    end
    rst_n = 1'b1;
    v8 = 1'b0;

    // 1-bit truth table, back-to-back
    for (int i = 0; i < 8; i++) begin
      v1 = 1'b1; a1 = tbl1[i].a; b1 = tbl1[i].b; c1 = tbl1[i].cin;
      tick();
      check($sformatf("tt_cs_%0d", i), {co1, s1}, tbl1[i].exp_cs);
      check($sformatf("tt_ovf_%0d", i), ov1, tbl1[i].exp_ovf);
      check($sformatf("tt_valid_%0d", i), vo1, 1'b1);
    end
    v1 = 1'b0;

    // 8-bit boundary vectors, back-to-back
    for (int i = 0; i < 6; i++) begin
      v8 = 1'b1; a8 = tbl8[i].a; b8 = tbl8[i].b; c8 = tbl8[i].cin;
      tick();
      check($sformatf("w8_sum_%0d", i), s8, tbl8[i].exp_sum);
      check($sformatf("w8_co_%0d", i), co8, tbl8[i].exp_co);
      check($sformatf("w8_ovf_%0d", i), ov8, tbl8[i].exp_ovf);
      check($sformatf("w8_valid_%0d", i), vo8, 1'b1);
    end

    // hold: one valid beat then idle with junk/unknown data
    v8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
    tick();
    check("hold_first_sum", s8, 8'h46);
    check("hold_first_valid", vo8, 1'b1);
    for (int k = 0; k < 3; k++) begin
      v8 = 1'b0;
      if (k == 1) begin
        a8 = 'x; b8 = 'x; c8 = 1'bx;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      end
      tick();
      check($sformatf("hold_sum_%0d", k), s8, 8'h46);
      check($sformatf("hold_valid_%0d", k), vo8, 1'b0);
    end

    // reset between edges has no effect until the next edge
    v8 = 1'b1; a8 = 8'h55; b8 = 8'h22; c8 = 1'b1;
    rst_n = 1'b0;
    #2;
    check("async_ignored_sum", s8, 8'h46);
    tick();
    check("midrst_sum", s8, 8'h00);
    check("midrst_co_ovf", {co8, ov8}, 2'b00);
    check("midrst_valid", vo8, 1'b0);
    rst_n = 1'b1;
    v8 = 1'b0;
    tick();
    m_res = 10'd0;
    m_valid = 1'b0;
    check("post_rst_idle_valid", vo8, 1'b0);

    // randomized regression against the reference model
    for (int i = 0; i < 40; i++) begin
      v8 = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      if (v8) begin
        m_res = ref8(a8, b8, c8);
        exp_q.push_back(m_res);
      end
      m_valid = v8;
      tick();
      check($sformatf("rnd_valid_%0d", i), vo8, m_valid);
      check($sformatf("rnd_state_%0d", i), {ov8, co8, s8}, m_res);
      if (vo8) begin
        if (exp_q.size() == 0) begin
          check($sformatf("rnd_unexpected_%0d", i), 1'b1, 1'b0);
        end else begin
          got = exp_q.pop_front();
          check($sformatf("rnd_sb_%0d", i), {ov8, co8, s8}, got);
        end
      end
    end
    v8 = 1'b0;
    tick();
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered full adder: adds two WIDTH-bit operands and a carry-in, giving a WIDTH-bit sum, a carry-out and a signed-overflow flag.
- Built as a ripple chain of one-bit full-adder cells with registered outputs.
- Used as a leaf arithmetic primitive in datapaths and ALUs.
- Default WIDTH=1 gives the classic 1-bit full adder with one cycle of latency.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- Clock_In  input  1  single clock; all state updates on the rising edge.
- Reset_N_In  input  1  synchronous, active-low reset.
- Valid_In  input  1  qualifies Data_A_In, Data_B_In and Carry_In in the current cycle.
- Data_A_In  input  WIDTH  operand A (unsigned, or two's complement for Overflow_Out).
- Data_B_In  input  WIDTH  operand B.
- Carry_In  input  1  carry into bit 0.
- Valid_Out  output  1  high for one cycle when Sum_Out, Carry_Out and Overflow_Out carry a new result.
- Sum_Out  output  WIDTH  registered sum bits.
- Carry_Out  output  1  registered carry out of bit WIDTH-1.
- Overflow_Out  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Combinational core:
  - Bit i: s[i] = a[i]^b[i]^c[i]; c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i]).
  - c[0] = Carry_In.
  - Equivalent to {c[WIDTH], s} = A + B + Carry_In, computed at WIDTH+1 bits; no truncation of the carry.
- Overflow: ovf = c[WIDTH] ^ c[WIDTH-1]. For WIDTH=1, c[0] is Carry_In, so ovf = Carry_Out ^ Carry_In.
- Reset: on a rising Clock_In edge with Reset_N_In=0:
  - Sum_Out=0, Carry_Out=0, Overflow_Out=0, Valid_Out=0.
  - Reset has priority over Valid_In.
  - Reset is synchronous only: asserting Reset_N_In between edges has no effect until the next edge.
- Normal operation: on a rising edge with Reset_N_In=1 and Valid_In=1:
  - Sum_Out, Carry_Out and Overflow_Out load the core results.
  - Valid_Out goes to 1.
- Idle: on a rising edge with Reset_N_In=1 and Valid_In=0:
  - Sum_Out, Carry_Out and Overflow_Out hold their last values.
  - Valid_Out goes to 0.
- Latency and throughput:
  - Exactly one cycle from the input edge to Valid_Out and the result.
  - One result per cycle; back-to-back Valid_In accepted every cycle.
  - No stall or backpressure.
- Wrap-around: all-ones + all-ones + 1 gives Sum_Out all-ones and Carry_Out=1. No saturation.
- Reset mid-stream: any result pending from the previous cycle is discarded; Valid_Out=0 after the reset edge.
- X/Z on data inputs while Valid_In=0 must not disturb registered outputs.
- Outputs are driven only from registers; no combinational input-to-output path.

Test Plan:
- Reset: hold Reset_N_In=0 for 2 cycles with Valid_In=1 and A=1, B=1, Cin=1 -> Sum_Out=0, Carry_Out=0, Overflow_Out=0, Valid_Out=0 after each edge.
- Exhaustive 1-bit truth table at WIDTH=1, all 8 {A,B,Cin} combinations back-to-back with Valid_In=1 -> one cycle later {Carry_Out,Sum_Out} = A+B+Cin (e.g. 1,1,0 -> 10; 1,1,1 -> 11; 0,1,1 -> 10; 0,0,0 -> 00), Valid_Out=1 every cycle.
- Wrap at WIDTH=8: A=0xFF, B=0x01, Cin=0 -> Sum_Out=0x00, Carry_Out=1, Overflow_Out=0. A=0xFF, B=0xFF, Cin=1 -> Sum_Out=0xFF, Carry_Out=1.
- Signed overflow at WIDTH=8: A=0x7F, B=0x01, Cin=0 -> Sum_Out=0x80, Carry_Out=0, Overflow_Out=1. A=0x80, B=0x80 -> Sum_Out=0x00, Carry_Out=1, Overflow_Out=1.
- Hold and reset mid-stream:
  - Valid_In=1 with A=0x12, B=0x34, then Valid_In=0 for 3 cycles with random data -> Sum_Out stays 0x46 and Valid_Out=1 then 0.
  - Then drop Reset_N_In for one edge -> all outputs 0.
- Random regression: 20+ random {A,B,Cin} vectors at 10 ns spacing with random Valid_In -> every Valid_Out cycle matches a reference model of A+B+Cin.
